multi_digit_seven_segment_scanner: RTL and testbench
====================================================

MULTI_DIGIT_SEVEN_SEGMENT_SCANNER -- requirements
Module: multi_digit_seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 2..8.
REQ-002 Parameter CLKS_PER_DIGIT, default 25000: clocks each digit stays selected, legal minimum 4.
REQ-003 Parameter DEAD_CLKS, default 2: blanking clocks at the start of each digit slot, legal range below CLKS_PER_DIGIT.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, segment and digit-enable outputs drive 0 for "on".
REQ-005 i_Clk input 1: sole clock, rising edge.
REQ-006 i_Rst_L input 1: asynchronous, active-low reset.
REQ-007 i_Load input 1: one-cycle strobe that captures i_Value.
REQ-008 i_Value input 4*NUM_DIGITS: hex nibbles, digit 0 in bits [3:0] (least significant digit).
REQ-009 i_Blank_Lz input 1: enables leading-zero blanking.
REQ-010 o_Segments output 7: segments A..G for the digit currently selected, bit 0 = A.
REQ-011 o_Digit_En output NUM_DIGITS: one-hot digit select, or all inactive.
REQ-012 o_Pending output 1: a captured value is waiting for a frame boundary.

Function
REQ-013 Slot counter counts 0..CLKS_PER_DIGIT-1; at the terminal count it wraps to 0 and advances the digit index.
REQ-014 Digit index runs 0..NUM_DIGITS-1 and wraps to 0; the index wrap is the frame boundary.
REQ-015 While slot count < DEAD_CLKS, all digit enables and all segments are inactive.
REQ-016 Otherwise, o_Digit_En selects the current index and o_Segments shows the decoded nibble of the display register.
REQ-017 Decoding is the standard hex font 0-F, with lowercase b and d.
REQ-018 Outputs are registered, one cycle after the internal counter and index state.
REQ-019 i_Load writes i_Value into the pending register and sets o_Pending.
REQ-020 At a frame boundary with o_Pending=1, the pending register copies to the display register and o_Pending clears.
REQ-021 i_Load in the same cycle as a frame boundary writes i_Value directly to the display register and leaves o_Pending at 0.
REQ-022 Repeated i_Load before a boundary overwrites the pending register; the last value wins.
REQ-023 Leading-zero blanking with i_Blank_Lz=1: digits above the highest nonzero nibble are displayed with all segments off; their digit enable still asserts.
REQ-024 Digit 0 is never blanked; the value 0 displays "0".

Reset
REQ-025 On i_Rst_L low, immediately and asynchronously: slot counter 0, index 0, display and pending registers 0, o_Pending 0, all segments and digit enables inactive.
REQ-026 Reset asserted mid-slot or mid-frame discards any pending value; after release, scanning restarts at digit 0 with a dead-time period.

Configuration
REQ-027 Macro SEG_SCAN_BLINK_EN, when defined, adds input i_Blink_Mask (NUM_DIGITS) and parameter BLINK_FRAMES (default 64).
REQ-028 With SEG_SCAN_BLINK_EN defined: a frame counter toggles a blink phase every BLINK_FRAMES frames; during the off phase, masked digits show all segments off. The frame counter and phase reset to 0.
REQ-029 Without SEG_SCAN_BLINK_EN: no i_Blink_Mask port, no frame counter, and no blink logic.

Structure
REQ-030 Shared package seven_seg_pkg holds the 16-entry hex-to-segment constant table, the segment bit-index constants and the blank-pattern constant.
REQ-031 Sub-module seg_hex_decode (nibble to 7 bits, combinational, polarity-neutral) is instantiated once on the muxed nibble; polarity inversion is applied at the output register.

Verification
REQ-032 Bench parameters are NUM_DIGITS=4, CLKS_PER_DIGIT=8, DEAD_CLKS=1, ACTIVE_LOW=0.
REQ-033 Reset then release, no load -> all enables 0 at cycle 1; then digits 0,1,2,3 each show 0x3F for 7 of every 8 cycles; frame period 32 cycles.
REQ-034 Load 0x12AF mid-frame -> o_Pending=1 until the next boundary; then digit 0=0x71 (F), digit 1=0x77 (A), digit 2=0x5B, digit 3=0x06.
REQ-035 Load 0x0007 with i_Blank_Lz=1 -> digits 3..1 segments 0x00 with enables pulsing; digit 0=0x07. Load 0x0000 -> digit 0=0x3F.
REQ-036 Load 0x1111 on the boundary cycle, then load 0x2222 and 0x3333 within one frame -> the first appears with no pending; the next frame shows 0x3333.
REQ-037 Assert i_Rst_L low at slot count 5 of digit 2 with a load pending -> outputs inactive the same cycle; after release, digit 0 is first and shows 0x3F.
REQ-038 With SEG_SCAN_BLINK_EN, BLINK_FRAMES=2 and mask 4'b0001 -> digit 0 is dark on alternate 2-frame periods; the other digits are unaffected.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants for the seven-segment scanner:
//   SEG_A..SEG_G : bit index of each segment inside a 7-bit segment vector
//   SEG_BLANK    : all segments off (active-high sense)
//   HEX_FONT     : nibble -> segment pattern, active-high, bit 0 = A
//                  standard hex font with lowercase b and d
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_FONT [0:15] = '{
        7'h3F, // 0
        7'h06, // 1
        7'h5B, // 2
        7'h4F, // 3
        7'h66, // 4
        7'h6D, // 5
        7'h7D, // 6
        7'h07, // 7
        7'h7F, // 8
        7'h6F, // 9
        7'h77, // A
        7'h7C, // b
        7'h39, // C
        7'h5E, // d
        7'h79, // E
        7'h71  // F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
// Combinational nibble to seven-segment decoder, active-high (polarity is
// applied by the caller at its output register).
// Ports:
//   nibble   : 4-bit hex digit
//   segments : segment pattern, bit 0 = A .. bit 6 = G, 1 = lit
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX_FONT[nibble];

endmodule

// File: rtl/multi_digit_seven_segment_scanner.sv
// multi_digit_seven_segment_scanner
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus. Each
// digit slot lasts CLKS_PER_DIGIT clocks, the first DEAD_CLKS of which are
// blanked to avoid ghosting while the digit select changes. New values are
// staged in a pending register and only reach the display at a frame
// boundary so a frame never shows a mix of old and new digits.
// Optional feature: define SEG_SCAN_BLINK_EN to add i_Blink_Mask and the
// BLINK_FRAMES parameter (per-digit blinking with a frame-based period).
// Ports:
//   i_Clk        : clock, rising edge
//   i_Rst_L      : asynchronous active-low reset
//   i_Load       : one-cycle strobe capturing i_Value
//   i_Value      : hex nibbles, digit 0 in [3:0]
//   i_Blank_Lz   : suppress leading zeros (digit 0 always shown)
//   i_Blink_Mask : digits to blink (SEG_SCAN_BLINK_EN only)
//   o_Segments   : segments A..G of the selected digit, bit 0 = A
//   o_Digit_En   : one-hot digit select, or all inactive in dead time
//   o_Pending    : a loaded value waits for the next frame boundary
module multi_digit_seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int DEAD_CLKS      = 2,
    parameter int ACTIVE_LOW     = 1
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 64
`endif
)
(
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Load,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Blank_Lz,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   i_Blink_Mask,
`endif
    output logic [6:0]              o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Pending
);

    localparam int SLOT_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CLKS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF =
        (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] EN_OFF =
        (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pending;

    logic                    slot_last;
    logic                    frame_boundary;
    logic                    in_dead;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [3:0]              cur_nibble;
    logic [6:0]              font_seg;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   dark_mask;
    logic                    zeros_above;
    logic                    digit_dark;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   en_next;

    assign slot_last      = (slot_cnt == SLOT_LAST);
    assign frame_boundary = slot_last && (digit_idx == IDX_LAST);
    assign in_dead        = (slot_cnt < DEAD_END);

    // Slot timer and digit index
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            slot_cnt  <= slot_cnt + SLOT_W'(1);
        end
    end

    // Load staging. A load that coincides with the boundary would otherwise
    // sit in pending for a whole frame, so it goes straight to the display.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            display_reg <= '0;
            pend_reg    <= '0;
            pending     <= 1'b0;
        end else if (frame_boundary) begin
            if (i_Load) begin
                display_reg <= i_Value;
            end else if (pending) begin
                display_reg <= pend_reg;
            end
            pending <= 1'b0;
        end else if (i_Load) begin
            pend_reg <= i_Value;
            pending  <= 1'b1;
        end
    end

    assign o_Pending = pending;

    always_comb begin
        sel_onehot = '0;
        cur_nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_onehot[i] = (digit_idx == IDX_W'(i));
            if (sel_onehot[i]) begin
                cur_nibble = display_reg[i*4 +: 4];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble   (cur_nibble),
        .segments (font_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zeros_above = 1'b1;
        lz_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (display_reg[i*4 +: 4] != 4'h0) begin
                zeros_above = 1'b0;
            end
            lz_mask[i] = zeros_above & i_Blank_Lz;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    // blink_phase = 1 is the dark half of the blink period
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_boundary) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + FRM_W'(1);
            end
        end
    end

    assign dark_mask = lz_mask | (blink_phase ? i_Blink_Mask : '0);
`else
    assign dark_mask = lz_mask;
`endif

    assign digit_dark = |(dark_mask & sel_onehot);

    // Dark digits keep their enable so the scan duty stays uniform.
    always_comb begin
        seg_next = font_seg;
        en_next  = sel_onehot;
        if (in_dead) begin
            seg_next = SEG_BLANK;
            en_next  = '0;
        end else if (digit_dark) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Segments <= SEG_OFF;
            o_Digit_En <= EN_OFF;
        end else begin
            o_Segments <= (ACTIVE_LOW != 0) ? ~seg_next : seg_next;
            o_Digit_En <= (ACTIVE_LOW != 0) ? ~en_next  : en_next;
        end
    end

endmodule

// File: tb/tb_multi_digit_seven_segment_scanner.sv
// Directed bench for multi_digit_seven_segment_scanner with 4 digits,
// 8 clocks per digit, 1 dead clock, active-high outputs (frame = 32 clocks).
// cyc counts rising edges since reset release; outputs seen after edge k
// describe scan position (k-1) mod 32.
module tb_multi_digit_seven_segment_scanner;

    localparam int ND  = 4;
    localparam int CPD = 8;
    localparam int DC  = 1;
    localparam int FRM = ND * CPD;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L;
    logic          i_Load;
    logic [15:0]   i_Value;
    logic          i_Blank_Lz;
`ifdef SEG_SCAN_BLINK_EN
    logic [ND-1:0] i_Blink_Mask;
`endif
    logic [6:0]    o_Segments;
    logic [ND-1:0] o_Digit_En;
    logic          o_Pending;

    int cyc;
    int checks;
    int errors;

    always #5 i_Clk = ~i_Clk;

    multi_digit_seven_segment_scanner #(
        .NUM_DIGITS     (ND),
        .CLKS_PER_DIGIT (CPD),
        .DEAD_CLKS      (DC),
        .ACTIVE_LOW     (0)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES   (2)
`endif
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Load       (i_Load),
        .i_Value      (i_Value),
        .i_Blank_Lz   (i_Blank_Lz),
`ifdef SEG_SCAN_BLINK_EN
        .i_Blink_Mask (i_Blink_Mask),
`endif
        .o_Segments   (o_Segments),
        .o_Digit_En   (o_Digit_En),
        .o_Pending    (o_Pending)
    );

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge i_Clk);
        cyc = cyc + 1;
        @(negedge i_Clk);
    endtask

    task automatic goto_pos(input int p);
        for (int n = 0; n < FRM && (cyc % FRM) != p; n++) tick();
    endtask

    task automatic test_reset();
        i_Rst_L    = 1'b0;
        i_Load     = 1'b0;
        i_Value    = 16'h0;
        i_Blank_Lz = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        i_Blink_Mask = '0;
`endif
        repeat (3) @(negedge i_Clk);
        checks++;
        if (o_Digit_En !== 4'b0000 || o_Segments !== 7'h00 || o_Pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold en=%b seg=%h pend=%b exp en=0000 seg=00 pend=0",
                     o_Digit_En, o_Segments, o_Pending);
        end
        i_Rst_L = 1'b1;
        cyc = 0;
        tick();
        checks++;
        if (o_Digit_En !== 4'b0000 || o_Segments !== 7'h00) begin
            errors++;
            $display("FAIL reset_cycle1 en=%b seg=%h exp en=0000 seg=00", o_Digit_En, o_Segments);
        end
        tick();
        checks++;
        if (o_Digit_En !== 4'b0001 || o_Segments !== 7'h3F) begin
            errors++;
            $display("FAIL reset_cycle2 en=%b seg=%h exp en=0001 seg=3f", o_Digit_En, o_Segments);
        end
    endtask

    task automatic test_idle_scan();
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        int p, slot, idx, d0_on;
        d0_on = 0;
        goto_pos(0);
        for (int n = 0; n < FRM; n++) begin
            tick();
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg = (slot < DC) ? 7'h00 : 7'h3F;
            if (o_Digit_En === 4'b0001) d0_on++;
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg) begin
                errors++;
                $display("FAIL idle_scan cyc=%0d en=%b seg=%h exp en=%b seg=%h",
                         cyc, o_Digit_En, o_Segments, exp_en, exp_seg);
            end
        end
        checks++;
        if (d0_on != CPD - DC) begin
            errors++;
            $display("FAIL idle_digit0_duty got=%0d exp=%0d", d0_on, CPD - DC);
        end
    endtask

    task automatic test_load_mid_frame();
        logic [6:0]    exp_digit [ND];
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        int p, slot, idx;
        exp_digit = '{7'h71, 7'h77, 7'h5B, 7'h06};
        goto_pos(5);
        i_Value = 16'h12AF; i_Load = 1'b1;
        tick();
        i_Load = 1'b0;
        checks++;
        if (o_Pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending_set got=%b exp=1", o_Pending);
        end
        goto_pos(FRM - 1);
        checks++;
        if (o_Pending !== 1'b1 || o_Segments !== 7'h3F) begin
            errors++;
            $display("FAIL load_pending_hold pend=%b seg=%h exp pend=1 seg=3f", o_Pending, o_Segments);
        end
        tick();
        checks++;
        if (o_Pending !== 1'b0) begin
            errors++;
            $display("FAIL load_pending_clear got=%b exp=0", o_Pending);
        end
        for (int n = 0; n < FRM; n++) begin
            tick();
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg = (slot < DC) ? 7'h00 : exp_digit[idx];
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg) begin
                errors++;
                $display("FAIL load_12af cyc=%0d en=%b seg=%h exp en=%b seg=%h",
                         cyc, o_Digit_En, o_Segments, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [15:0]   vals [3];
        logic [6:0]    exp_tab [3][ND];
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        int p, slot, idx;
        vals    = '{16'h0007, 16'h0000, 16'h0105};
        exp_tab = '{'{7'h07, 7'h00, 7'h00, 7'h00},
                    '{7'h3F, 7'h00, 7'h00, 7'h00},
                    '{7'h6D, 7'h3F, 7'h06, 7'h00}};
        i_Blank_Lz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            goto_pos(7);
            i_Value = vals[v]; i_Load = 1'b1;
            tick();
            i_Load = 1'b0;
            goto_pos(0);
            for (int n = 0; n < FRM; n++) begin
                tick();
                p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
                exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
                exp_seg = (slot < DC) ? 7'h00 : exp_tab[v][idx];
                checks++;
                if (o_Digit_En !== exp_en || o_Segments !== exp_seg) begin
                    errors++;
                    $display("FAIL blank_lz val=%h cyc=%0d en=%b seg=%h exp en=%b seg=%h",
                             vals[v], cyc, o_Digit_En, o_Segments, exp_en, exp_seg);
                end
            end
        end
        i_Blank_Lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        logic          exp_pend;
        int p, slot, idx;
        goto_pos(FRM - 1);
        i_Value = 16'h1111; i_Load = 1'b1;
        tick();
        i_Load = 1'b0;
        checks++;
        if (o_Pending !== 1'b0) begin
            errors++;
            $display("FAIL b2b_boundary_load_pending got=%b exp=0", o_Pending);
        end
        for (int n = 0; n < FRM; n++) begin
            i_Load  = (n == 0 || n == 9);
            i_Value = (n == 0) ? 16'h2222 : 16'h3333;
            tick();
            i_Load = 1'b0;
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            exp_en   = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg  = (slot < DC) ? 7'h00 : 7'h06;
            exp_pend = (n < FRM - 1);
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg || o_Pending !== exp_pend) begin
                errors++;
                $display("FAIL b2b_first cyc=%0d en=%b seg=%h pend=%b exp en=%b seg=%h pend=%b",
                         cyc, o_Digit_En, o_Segments, o_Pending, exp_en, exp_seg, exp_pend);
            end
        end
        for (int n = 0; n < FRM; n++) begin
            tick();
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg = (slot < DC) ? 7'h00 : 7'h4F;
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg || o_Pending !== 1'b0) begin
                errors++;
                $display("FAIL b2b_last_wins cyc=%0d en=%b seg=%h pend=%b exp en=%b seg=%h pend=0",
                         cyc, o_Digit_En, o_Segments, o_Pending, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        int p, slot, idx;
        goto_pos(3);
        i_Value = 16'hABCD; i_Load = 1'b1;
        tick();
        i_Load = 1'b0;
        goto_pos(2 * CPD + 5);
        checks++;
        if (o_Digit_En !== 4'b0100 || o_Segments !== 7'h4F || o_Pending !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_before en=%b seg=%h pend=%b exp en=0100 seg=4f pend=1",
                     o_Digit_En, o_Segments, o_Pending);
        end
        #2;
        i_Rst_L = 1'b0;
        #1;
        checks++;
        if (o_Digit_En !== 4'b0000 || o_Segments !== 7'h00 || o_Pending !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async en=%b seg=%h pend=%b exp en=0000 seg=00 pend=0",
                     o_Digit_En, o_Segments, o_Pending);
        end
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        cyc = 0;
        tick();
        checks++;
        if (o_Digit_En !== 4'b0000 || o_Segments !== 7'h00) begin
            errors++;
            $display("FAIL rst_mid_dead en=%b seg=%h exp en=0000 seg=00", o_Digit_En, o_Segments);
        end
        tick();
        checks++;
        if (o_Digit_En !== 4'b0001 || o_Segments !== 7'h3F) begin
            errors++;
            $display("FAIL rst_mid_first en=%b seg=%h exp en=0001 seg=3f", o_Digit_En, o_Segments);
        end
        goto_pos(0);
        for (int n = 0; n < FRM; n++) begin
            tick();
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg = (slot < DC) ? 7'h00 : 7'h3F;
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg || o_Pending !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_discard cyc=%0d en=%b seg=%h pend=%b exp en=%b seg=%h pend=0",
                         cyc, o_Digit_En, o_Segments, o_Pending, exp_en, exp_seg);
            end
        end
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        logic [6:0]    exp_seg;
        logic [ND-1:0] exp_en;
        int p, slot, idx, frame;
        i_Rst_L = 1'b0;
        i_Blink_Mask = 4'b0001;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        cyc = 0;
        for (int n = 0; n < 6 * FRM; n++) begin
            tick();
            p = (cyc - 1) % FRM; slot = p % CPD; idx = p / CPD;
            frame = (cyc - 1) / FRM;
            exp_en  = (slot < DC) ? 4'b0000 : 4'(1 << idx);
            exp_seg = (slot < DC) ? 7'h00 :
                      (idx == 0 && ((frame / 2) % 2) == 1) ? 7'h00 : 7'h3F;
            checks++;
            if (o_Digit_En !== exp_en || o_Segments !== exp_seg) begin
                errors++;
                $display("FAIL blink cyc=%0d en=%b seg=%h exp en=%b seg=%h",
                         cyc, o_Digit_En, o_Segments, exp_en, exp_seg);
            end
        end
        i_Blink_Mask = 4'b0000;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_idle_scan();
        test_load_mid_frame();
        test_blank_lz();
        test_back_to_back();
        test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
